// File: rtl/field_op_arbiter.sv
// Grants the shared GF(2^m) arithmetic core to one of three sequence controllers,
// forwards the owner's command, tracks the single in-flight operation and routes completions.
module field_op_arbiter #(
   parameter int unsigned TIMEOUT = 1023
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] req,
   input  logic [11:0] req_cmd,
   input  logic [8:0] req_raddr,
   input  logic [8:0] req_waddr,
   input  logic [2:0] req_sel_ab,
   input  logic [2:0] req_sel_cd,
   input  logic [5:0] req_chunk,
   output logic [2:0] grant,
   output logic [3:0] b_command,
   output logic [2:0] read_addr,
   output logic [2:0] write_addr,
   output logic       select_Ram_A_Or_B,
   output logic       select_Ram_C_Or_D,
   output logic [1:0] numbr_of_chunk,
   input  logic       interupt_sqr,
   input  logic       interupt_red,
   input  logic       interupt_swap,
   input  logic       interupt_mul,
   output logic [2:0] done_sqr,
   output logic [2:0] done_red,
   output logic [2:0] done_swap,
   output logic [2:0] done_mul,
   output logic       busy,
   output logic       err_cmd,
   output logic       err_timeout,
   output logic [1:0] dbg_state_o
);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_OWNED = 2'd1, ST_DRAIN = 2'd2} state_t;

   localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);

   state_t     state_q, state_d;
   logic [1:0] owner_q, owner_d;
   logic [2:0] grant_q, grant_d;
   logic [3:0] bcmd_q, bcmd_d;
   logic [2:0] raddr_q, raddr_d, waddr_q, waddr_d;
   logic       sel_ab_q, sel_ab_d, sel_cd_q, sel_cd_d;
   logic [1:0] chunk_q, chunk_d;
   logic [2:0] done_sqr_q, done_sqr_d, done_red_q, done_red_d;
   logic [2:0] done_swap_q, done_swap_d, done_mul_q, done_mul_d;
   logic       busy_q, busy_d;
   logic       err_cmd_q, err_cmd_d, err_tmo_q, err_tmo_d;
   logic [3:0] exp_q, exp_d;
   logic [9:0] cnt_q, cnt_d;

   logic [3:0] cmd_a   [4];
   logic [2:0] raddr_a [4];
   logic [2:0] waddr_a [4];
   logic [1:0] chunk_a [4];
   logic [3:0] req_a, sel_ab_a, sel_cd_a;

   logic [3:0] irq_vec, own_code, own_cmd;
   logic       own_active, completion, timeout_hit, accept, own_reject, foreign_cmd;
   logic       pick_found;
   logic [1:0] pick_idx, scan_idx;

   // Expected-interrupt mask bit order: {swap, red, sqr, mul}.
   function automatic logic [3:0] decode_cmd(input logic [3:0] c);
      case (c)
         4'd1:    decode_cmd = 4'b0001;
         4'd2:    decode_cmd = 4'b0010;
         4'd4:    decode_cmd = 4'b0100;
         4'd5:    decode_cmd = 4'b1000;
         default: decode_cmd = 4'b0000;
      endcase
   endfunction

   function automatic logic [1:0] next_idx(input logic [1:0] i);
      next_idx = (i == 2'd2) ? 2'd0 : i + 2'd1;
   endfunction

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         cmd_a[i]   = req_cmd[4*i +: 4];
         raddr_a[i] = req_raddr[3*i +: 3];
         waddr_a[i] = req_waddr[3*i +: 3];
         chunk_a[i] = req_chunk[2*i +: 2];
      end
      cmd_a[3]   = '0;
      raddr_a[3] = '0;
      waddr_a[3] = '0;
      chunk_a[3] = '0;
      req_a      = {1'b0, req};
      sel_ab_a   = {1'b0, req_sel_ab};
      sel_cd_a   = {1'b0, req_sel_cd};
   end

   assign irq_vec     = {interupt_swap, interupt_red, interupt_sqr, interupt_mul};
   assign own_active  = (state_q == ST_OWNED);
   assign own_cmd     = cmd_a[owner_q];
   assign own_code    = decode_cmd(own_cmd);
   assign completion  = busy_q && |(exp_q & irq_vec);
   assign timeout_hit = busy_q && !completion && (cnt_q == TMO_LAST);
   // A new command may ride on the same edge as the completion of the previous one.
   assign accept      = own_active && (own_code != 4'd0) && (!busy_q || completion);
   assign own_reject  = own_active && (own_cmd != 4'd0) && !accept;
   assign busy_d      = accept ? 1'b1 : ((completion || timeout_hit) ? 1'b0 : busy_q);

   always_comb begin
      foreign_cmd = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if ((cmd_a[i] != 4'd0) && !(own_active && (owner_q == 2'(i)))) foreign_cmd = 1'b1;
      end
   end

   // Round-robin scan starts just after the previous owner.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = 2'd0;
      scan_idx   = next_idx(owner_q);
      for (int k = 0; k < 3; k++) begin
         if (!pick_found && req_a[scan_idx]) begin
            pick_found = 1'b1;
            pick_idx   = scan_idx;
         end
         scan_idx = next_idx(scan_idx);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (pick_found) state_d = ST_OWNED;
         ST_OWNED: if (!req_a[owner_q]) state_d = busy_d ? ST_DRAIN : ST_IDLE;
         ST_DRAIN: if (!busy_d) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      owner_d  = owner_q;
      grant_d  = grant_q;
      raddr_d  = raddr_q;
      waddr_d  = waddr_q;
      sel_ab_d = sel_ab_q;
      sel_cd_d = sel_cd_q;
      chunk_d  = chunk_q;
      if (state_q == ST_IDLE && state_d == ST_OWNED) begin
         owner_d = pick_idx;
         grant_d = 3'b001 << pick_idx;
      end else if (state_d == ST_IDLE) begin
         grant_d = '0;
      end
      if (own_active) begin
         raddr_d  = raddr_a[owner_q];
         waddr_d  = waddr_a[owner_q];
         sel_ab_d = sel_ab_a[owner_q];
         sel_cd_d = sel_cd_a[owner_q];
         chunk_d  = chunk_a[owner_q];
      end
      bcmd_d      = accept ? own_cmd : 4'd0;
      exp_d       = accept ? own_code : exp_q;
      cnt_d       = (accept || !busy_q || completion || timeout_hit) ? 10'd0 : cnt_q + 10'd1;
      done_sqr_d  = interupt_sqr  ? grant_q : 3'b000;
      done_red_d  = interupt_red  ? grant_q : 3'b000;
      done_swap_d = interupt_swap ? grant_q : 3'b000;
      done_mul_d  = interupt_mul  ? grant_q : 3'b000;
      err_cmd_d   = own_reject || foreign_cmd;
      err_tmo_d   = timeout_hit;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         owner_q     <= 2'd2;
         grant_q     <= '0;
         bcmd_q      <= '0;
         raddr_q     <= '0;
         waddr_q     <= '0;
         sel_ab_q    <= 1'b0;
         sel_cd_q    <= 1'b0;
         chunk_q     <= '0;
         done_sqr_q  <= '0;
         done_red_q  <= '0;
         done_swap_q <= '0;
         done_mul_q  <= '0;
         busy_q      <= 1'b0;
         err_cmd_q   <= 1'b0;
         err_tmo_q   <= 1'b0;
         exp_q       <= '0;
         cnt_q       <= '0;
      end else begin
         owner_q     <= owner_d;
         grant_q     <= grant_d;
         bcmd_q      <= bcmd_d;
         raddr_q     <= raddr_d;
         waddr_q     <= waddr_d;
         sel_ab_q    <= sel_ab_d;
         sel_cd_q    <= sel_cd_d;
         chunk_q     <= chunk_d;
         done_sqr_q  <= done_sqr_d;
         done_red_q  <= done_red_d;
         done_swap_q <= done_swap_d;
         done_mul_q  <= done_mul_d;
         busy_q      <= busy_d;
         err_cmd_q   <= err_cmd_d;
         err_tmo_q   <= err_tmo_d;
         exp_q       <= exp_d;
         cnt_q       <= cnt_d;
      end
   end

   assign grant             = grant_q;
   assign b_command         = bcmd_q;
   assign read_addr         = raddr_q;
   assign write_addr        = waddr_q;
   assign select_Ram_A_Or_B = sel_ab_q;
   assign select_Ram_C_Or_D = sel_cd_q;
   assign numbr_of_chunk    = chunk_q;
   assign done_sqr          = done_sqr_q;
   assign done_red          = done_red_q;
   assign done_swap         = done_swap_q;
   assign done_mul          = done_mul_q;
   assign busy              = busy_q;
   assign err_cmd           = err_cmd_q;
   assign err_timeout       = err_tmo_q;
   assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_field_op_arbiter.sv
// Directed bench for field_op_arbiter: a default-timeout instance plus a short-timeout
// instance (TIMEOUT=8) driven from the same inputs.
module tb_field_op_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  req;
   logic [11:0] req_cmd;
   logic [8:0]  req_raddr, req_waddr;
   logic [2:0]  req_sel_ab, req_sel_cd;
   logic [5:0]  req_chunk;
   logic        interupt_sqr, interupt_red, interupt_swap, interupt_mul;

   logic [2:0] grant, read_addr, write_addr, done_sqr, done_red, done_swap, done_mul;
   logic [3:0] b_command;
   logic       select_Ram_A_Or_B, select_Ram_C_Or_D, busy, err_cmd, err_timeout;
   logic [1:0] numbr_of_chunk, dbg_state;

   logic [2:0] t_grant, t_read_addr, t_write_addr, t_done_sqr, t_done_red, t_done_swap, t_done_mul;
   logic [3:0] t_b_command;
   logic       t_sel_ab, t_sel_cd, t_busy, t_err_cmd, t_err_timeout;
   logic [1:0] t_chunk, t_dbg_state;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   field_op_arbiter dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_cmd(req_cmd),
      .req_raddr(req_raddr), .req_waddr(req_waddr),
      .req_sel_ab(req_sel_ab), .req_sel_cd(req_sel_cd), .req_chunk(req_chunk),
      .grant(grant), .b_command(b_command), .read_addr(read_addr), .write_addr(write_addr),
      .select_Ram_A_Or_B(select_Ram_A_Or_B), .select_Ram_C_Or_D(select_Ram_C_Or_D),
      .numbr_of_chunk(numbr_of_chunk),
      .interupt_sqr(interupt_sqr), .interupt_red(interupt_red),
      .interupt_swap(interupt_swap), .interupt_mul(interupt_mul),
      .done_sqr(done_sqr), .done_red(done_red), .done_swap(done_swap), .done_mul(done_mul),
      .busy(busy), .err_cmd(err_cmd), .err_timeout(err_timeout), .dbg_state_o(dbg_state)
   );

   field_op_arbiter #(.TIMEOUT(8)) dut_t (
      .clk(clk), .rst_n(rst_n), .req(req), .req_cmd(req_cmd),
      .req_raddr(req_raddr), .req_waddr(req_waddr),
      .req_sel_ab(req_sel_ab), .req_sel_cd(req_sel_cd), .req_chunk(req_chunk),
      .grant(t_grant), .b_command(t_b_command), .read_addr(t_read_addr), .write_addr(t_write_addr),
      .select_Ram_A_Or_B(t_sel_ab), .select_Ram_C_Or_D(t_sel_cd),
      .numbr_of_chunk(t_chunk),
      .interupt_sqr(interupt_sqr), .interupt_red(interupt_red),
      .interupt_swap(interupt_swap), .interupt_mul(interupt_mul),
      .done_sqr(t_done_sqr), .done_red(t_done_red), .done_swap(t_done_swap), .done_mul(t_done_mul),
      .busy(t_busy), .err_cmd(t_err_cmd), .err_timeout(t_err_timeout), .dbg_state_o(t_dbg_state)
   );

   // Advance one edge; outputs are then stable and new inputs land before the next edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      req = '0; req_cmd = '0; req_raddr = '0; req_waddr = '0;
      req_sel_ab = '0; req_sel_cd = '0; req_chunk = '0;
      interupt_sqr = 1'b0; interupt_red = 1'b0; interupt_swap = 1'b0; interupt_mul = 1'b0;
   endtask

   task automatic apply_reset();
      clear_inputs();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      checks++; if (grant !== 3'b000) begin failures++; $display("FAIL reset_grant got=%b exp=000", grant); end
      checks++; if (b_command !== 4'd0 || read_addr !== 3'd0 || write_addr !== 3'd0) begin
         failures++; $display("FAIL reset_core_out got=%h/%h/%h exp=0/0/0", b_command, read_addr, write_addr); end
      checks++; if ({select_Ram_A_Or_B, select_Ram_C_Or_D, numbr_of_chunk} !== 4'b0000) begin
         failures++; $display("FAIL reset_sel got=%b exp=0000", {select_Ram_A_Or_B, select_Ram_C_Or_D, numbr_of_chunk}); end
      checks++; if ({done_sqr, done_red, done_swap, done_mul} !== 12'h000) begin
         failures++; $display("FAIL reset_done got=%h exp=000", {done_sqr, done_red, done_swap, done_mul}); end
      checks++; if ({busy, err_cmd, err_timeout} !== 3'b000 || dbg_state !== 2'd0) begin
         failures++; $display("FAIL reset_flags got=%b st=%0d exp=000 st=0", {busy, err_cmd, err_timeout}, dbg_state); end
   endtask

   task automatic test_single_owner();
      apply_reset();
      req = 3'b001;
      step();
      checks++; if (grant !== 3'b001) begin failures++; $display("FAIL single_grant got=%b exp=001", grant); end
      req_cmd = 12'h002; req_raddr = 9'o004; req_waddr = 9'o005;
      req_sel_ab = 3'b001; req_chunk = 6'b000010;
      step();
      checks++; if (b_command !== 4'd2 || read_addr !== 3'd4 || write_addr !== 3'd5) begin
         failures++; $display("FAIL single_cmd got=%0d/%0d/%0d exp=2/4/5", b_command, read_addr, write_addr); end
      checks++; if (select_Ram_A_Or_B !== 1'b1 || numbr_of_chunk !== 2'd2 || busy !== 1'b1) begin
         failures++; $display("FAIL single_sel got=%b/%0d/%b exp=1/2/1", select_Ram_A_Or_B, numbr_of_chunk, busy); end
      req_cmd = '0;
      step();
      checks++; if (b_command !== 4'd0 || busy !== 1'b1) begin
         failures++; $display("FAIL single_pulse got=%0d/%b exp=0/1", b_command, busy); end
      interupt_sqr = 1'b1;
      step();
      interupt_sqr = 1'b0;
      checks++; if (done_sqr !== 3'b001 || busy !== 1'b0) begin
         failures++; $display("FAIL single_done got=%b/%b exp=001/0", done_sqr, busy); end
      req = 3'b000;
      step();
      checks++; if (done_sqr !== 3'b000 || grant !== 3'b000) begin
         failures++; $display("FAIL single_release got=%b/%b exp=000/000", done_sqr, grant); end
   endtask

   task automatic test_round_robin();
      apply_reset();
      req = 3'b111;
      step();
      for (int i = 0; i < 4; i++) begin
         int o;
         logic [2:0] eg;
         o = i % 3;
         eg = 3'b001 << o;
         checks++; if (grant !== eg) begin failures++; $display("FAIL rr_grant%0d got=%b exp=%b", i, grant, eg); end
         req_cmd = 12'h001 << (4 * o);
         step();
         req_cmd = '0;
         checks++; if (b_command !== 4'd1 || err_cmd !== 1'b0) begin
            failures++; $display("FAIL rr_cmd%0d got=%0d/%b exp=1/0", i, b_command, err_cmd); end
         interupt_mul = 1'b1;
         step();
         interupt_mul = 1'b0;
         checks++; if (done_mul !== eg) begin failures++; $display("FAIL rr_done%0d got=%b exp=%b", i, done_mul, eg); end
         req = 3'b111 & ~eg;
         step();
         checks++; if (grant !== 3'b000) begin failures++; $display("FAIL rr_idle%0d got=%b exp=000", i, grant); end
         req = 3'b111;
         step();
      end
   endtask

   task automatic test_reject();
      apply_reset();
      req = 3'b001;
      step();
      req_cmd = 12'h003;
      step();
      checks++; if (b_command !== 4'd0 || err_cmd !== 1'b1 || busy !== 1'b0) begin
         failures++; $display("FAIL rej_invalid got=%0d/%b/%b exp=0/1/0", b_command, err_cmd, busy); end
      req_cmd = '0;
      step();
      checks++; if (err_cmd !== 1'b0) begin failures++; $display("FAIL rej_pulse got=%b exp=0", err_cmd); end
      req_cmd = 12'h010;
      step();
      checks++; if (b_command !== 4'd0 || err_cmd !== 1'b1) begin
         failures++; $display("FAIL rej_foreign got=%0d/%b exp=0/1", b_command, err_cmd); end
      req_cmd = 12'h001;
      step();
      req_cmd = 12'h004;
      step();
      checks++; if (b_command !== 4'd0 || err_cmd !== 1'b1 || busy !== 1'b1) begin
         failures++; $display("FAIL rej_busy got=%0d/%b/%b exp=0/1/1", b_command, err_cmd, busy); end
      req_cmd = '0;
      interupt_sqr = 1'b1;
      step();
      interupt_sqr = 1'b0;
      checks++; if (done_sqr !== 3'b001 || busy !== 1'b1) begin
         failures++; $display("FAIL rej_wrong_irq got=%b/%b exp=001/1", done_sqr, busy); end
      interupt_mul = 1'b1;
      req_cmd = 12'h002;
      step();
      interupt_mul = 1'b0;
      req_cmd = '0;
      checks++; if (b_command !== 4'd2 || busy !== 1'b1 || done_mul !== 3'b001 || err_cmd !== 1'b0) begin
         failures++; $display("FAIL rej_same_edge got=%0d/%b/%b/%b exp=2/1/001/0", b_command, busy, done_mul, err_cmd); end
      interupt_sqr = 1'b1;
      step();
      interupt_sqr = 1'b0;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rej_final_busy got=%b exp=0", busy); end
   endtask

   task automatic test_drain();
      apply_reset();
      req = 3'b001;
      step();
      req_cmd = 12'h001;
      step();
      req_cmd = '0;
      req = 3'b000;
      step();
      checks++; if (grant !== 3'b001 || busy !== 1'b1 || dbg_state !== 2'd2) begin
         failures++; $display("FAIL drain_hold got=%b/%b/%0d exp=001/1/2", grant, busy, dbg_state); end
      for (int i = 0; i < 19; i++) step();
      checks++; if (grant !== 3'b001) begin failures++; $display("FAIL drain_wait got=%b exp=001", grant); end
      interupt_mul = 1'b1;
      step();
      interupt_mul = 1'b0;
      checks++; if (done_mul !== 3'b001 || grant !== 3'b000 || busy !== 1'b0) begin
         failures++; $display("FAIL drain_done got=%b/%b/%b exp=001/000/0", done_mul, grant, busy); end
   endtask

   task automatic test_timeout();
      apply_reset();
      req = 3'b001;
      step();
      req_cmd = 12'h005;
      step();
      req_cmd = '0;
      checks++; if (t_b_command !== 4'd5 || t_busy !== 1'b1) begin
         failures++; $display("FAIL tmo_cmd got=%0d/%b exp=5/1", t_b_command, t_busy); end
      for (int i = 0; i < 7; i++) step();
      checks++; if (t_busy !== 1'b1 || t_err_timeout !== 1'b0) begin
         failures++; $display("FAIL tmo_early got=%b/%b exp=1/0", t_busy, t_err_timeout); end
      step();
      checks++; if (t_busy !== 1'b0 || t_err_timeout !== 1'b1) begin
         failures++; $display("FAIL tmo_fire got=%b/%b exp=0/1", t_busy, t_err_timeout); end
      interupt_swap = 1'b1;
      step();
      interupt_swap = 1'b0;
      checks++; if (t_err_timeout !== 1'b0 || t_done_swap !== 3'b001 || t_busy !== 1'b0) begin
         failures++; $display("FAIL tmo_late got=%b/%b/%b exp=0/001/0", t_err_timeout, t_done_swap, t_busy); end
      req_cmd = 12'h002;
      step();
      req_cmd = '0;
      checks++; if (t_b_command !== 4'd2 || t_busy !== 1'b1 || t_err_cmd !== 1'b0) begin
         failures++; $display("FAIL tmo_next got=%0d/%b/%b exp=2/1/0", t_b_command, t_busy, t_err_cmd); end
   endtask

   task automatic test_reset_mid_op();
      apply_reset();
      req = 3'b001;
      step();
      req_cmd = 12'h001; req_raddr = 9'o007; req_sel_cd = 3'b001;
      step();
      req_cmd = '0;
      rst_n = 1'b0;
      step();
      checks++; if (grant !== 3'b000 || busy !== 1'b0 || b_command !== 4'd0) begin
         failures++; $display("FAIL rstmid_state got=%b/%b/%0d exp=000/0/0", grant, busy, b_command); end
      checks++; if (read_addr !== 3'd0 || select_Ram_C_Or_D !== 1'b0) begin
         failures++; $display("FAIL rstmid_addr got=%0d/%b exp=0/0", read_addr, select_Ram_C_Or_D); end
      rst_n = 1'b1;
      req = 3'b000;
      interupt_mul = 1'b1;
      step();
      interupt_mul = 1'b0;
      checks++; if (done_mul !== 3'b000 || busy !== 1'b0) begin
         failures++; $display("FAIL rstmid_stray got=%b/%b exp=000/0", done_mul, busy); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      clear_inputs();
      rst_n = 1'b0;
      test_reset();
      test_single_owner();
      test_round_robin();
      test_reject();
      test_drain();
      test_timeout();
      test_reset_mid_op();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
